// File: rtl/lcd_pkg.sv
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared constants, state codes and helpers for the LCD bus driver.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lcd_pkg;

  localparam int LCD_ON_BIT    = 31;
  localparam int LCD_START_BIT = 10;
  localparam int LCD_RW_BIT    = 9;
  localparam int LCD_RS_BIT    = 8;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_IDLE      = 3'd0;
  localparam lcd_state_t ST_SETUP     = 3'd1;
  localparam lcd_state_t ST_PULSE     = 3'd2;
  localparam lcd_state_t ST_HOLD      = 3'd3;
  localparam lcd_state_t ST_EXEC      = 3'd4;
`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_t ST_INIT_LOAD = 3'd5;
`endif

  // Power-on command list: function set, display on, clear, entry mode.
  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_clear_class(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_driver_if.sv
// ============================================================================
// Module : lcd_bus_driver_if
// Brief  : LCD panel pin bundle; master drives the pins, slave observes them.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lcd_bus_driver_if;

  logic [7:0] lcd_data;
  logic       lcd_data_oe;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  modport master (
    output lcd_data,
    output lcd_data_oe,
    output lcd_rs,
    output lcd_rw,
    output lcd_en,
    output lcd_on
  );

  modport slave (
    input lcd_data,
    input lcd_data_oe,
    input lcd_rs,
    input lcd_rw,
    input lcd_en,
    input lcd_on
  );

endinterface

`default_nettype wire

// File: rtl/lcd_delay_timer.sv
// ============================================================================
// Module : lcd_delay_timer
// Brief  : Loadable down-counter with a zero flag; holds at zero.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_bus_driver.sv
// ============================================================================
// Module : lcd_bus_driver
// Brief  : Runs timed HD44780 bus cycles from the LCD control register image.
//          Optional power-on command sequence under macro LCD_INIT_SEQ_EN.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_PULSE_CYC = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_CLEAR_CYC = 82000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_lcd_reg,
  lcd_bus_driver_if.master lcd,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP_CYC, T_PULSE_CYC),
                                               max_u(T_HOLD_CYC, T_EXEC_CYC)),
                                         T_CLEAR_CYC);
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // Counter is loaded with length-1 so a state lasts exactly its length.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR_CYC - 1);

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_t RESET_STATE = ST_INIT_LOAD;
`else
  localparam lcd_state_t RESET_STATE = ST_IDLE;
`endif

  lcd_state_t       state_q, state_d;
  logic             start_q;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic             oe_q, oe_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             on_q;

  logic             request;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;
  logic             unused_reg_bits;

`ifdef LCD_INIT_SEQ_EN
  logic             init_active_q, init_active_d;
  logic [1:0]       init_idx_q, init_idx_d;
`endif

  assign unused_reg_bits = &{1'b0, i_lcd_reg[30:11]};

  // Edges during a cycle (or init) are dropped, but start_q keeps tracking.
  assign request = (state_q == ST_IDLE) && i_lcd_reg[LCD_START_BIT] && !start_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_active_d = init_active_q;
    init_idx_d    = init_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          data_d  = i_lcd_reg[7:0];
          rs_d    = i_lcd_reg[LCD_RS_BIT];
          rw_d    = i_lcd_reg[LCD_RW_BIT];
          oe_d    = !i_lcd_reg[LCD_RW_BIT];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: if (timer_zero) state_d = ST_PULSE;
      ST_PULSE: if (timer_zero) state_d = ST_HOLD;
      ST_HOLD:  if (timer_zero) state_d = ST_EXEC;
      ST_EXEC: begin
        if (timer_zero) begin
`ifdef LCD_INIT_SEQ_EN
          if (init_active_q) begin
            if (init_idx_q == 2'(INIT_LEN - 1)) begin
              init_active_d = 1'b0;
              state_d       = ST_IDLE;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              state_d    = ST_INIT_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      ST_INIT_LOAD: begin
        data_d  = INIT_CMDS[init_idx_q];
        rs_d    = 1'b0;
        rw_d    = 1'b0;
        oe_d    = 1'b1;
        state_d = ST_SETUP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    timer_load  = (state_d != state_q);
    timer_value = '0;
    case (state_d)
      ST_SETUP: timer_value = LD_SETUP;
      ST_PULSE: timer_value = LD_PULSE;
      ST_HOLD:  timer_value = LD_HOLD;
      ST_EXEC:  timer_value = is_clear_class(rs_d, data_d) ? LD_CLEAR : LD_EXEC;
      default:  timer_value = '0;
    endcase

    en_d   = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  lcd_delay_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (timer_load),
    .i_value (timer_value),
    .o_zero  (timer_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RESET_STATE;
      start_q <= 1'b1;
      data_q  <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= i_lcd_reg[LCD_START_BIT];
      data_q  <= data_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      on_q    <= i_lcd_reg[LCD_ON_BIT];
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      init_active_q <= 1'b1;
      init_idx_q    <= 2'd0;
    end else begin
      init_active_q <= init_active_d;
      init_idx_q    <= init_idx_d;
    end
  end
`endif

  assign lcd.lcd_data    = data_q;
  assign lcd.lcd_data_oe = oe_q;
  assign lcd.lcd_rs      = rs_q;
  assign lcd.lcd_rw      = rw_q;
  assign lcd.lcd_en      = en_q;
  assign lcd.lcd_on      = on_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

`default_nettype wire
